// File: rtl/axi_4_lite_slv_param_if.sv
// AXI4-Lite bus bundle for the parametrised register-file slave.
// Address/data widths follow the slave's C_AXI_* parameters.
interface axi_4_lite_slv_param_if #(
   parameter int DW = 32,
   parameter int AW = 8
);
   logic          S_AXI_AWVALID;
   logic          S_AXI_AWREADY;
   logic [AW-1:0] S_AXI_AWADDR;
   logic [2:0]    S_AXI_AWPROT;
   logic          S_AXI_WVALID;
   logic          S_AXI_WREADY;
   logic [DW-1:0] S_AXI_WDATA;
   logic [DW/8-1:0] S_AXI_WSTRB;
   logic          S_AXI_BVALID;
   logic          S_AXI_BREADY;
   logic [1:0]    S_AXI_BRESP;
   logic          S_AXI_ARVALID;
   logic          S_AXI_ARREADY;
   logic [AW-1:0] S_AXI_ARADDR;
   logic [2:0]    S_AXI_ARPROT;
   logic          S_AXI_RVALID;
   logic          S_AXI_RREADY;
   logic [DW-1:0] S_AXI_RDATA;
   logic [1:0]    S_AXI_RRESP;

   modport slave (
      input  S_AXI_AWVALID, S_AXI_AWADDR, S_AXI_AWPROT,
      output S_AXI_AWREADY,
      input  S_AXI_WVALID, S_AXI_WDATA, S_AXI_WSTRB,
      output S_AXI_WREADY,
      output S_AXI_BVALID, S_AXI_BRESP,
      input  S_AXI_BREADY,
      input  S_AXI_ARVALID, S_AXI_ARADDR, S_AXI_ARPROT,
      output S_AXI_ARREADY,
      output S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP,
      input  S_AXI_RREADY
   );

   modport master (
      output S_AXI_AWVALID, S_AXI_AWADDR, S_AXI_AWPROT,
      input  S_AXI_AWREADY,
      output S_AXI_WVALID, S_AXI_WDATA, S_AXI_WSTRB,
      input  S_AXI_WREADY,
      input  S_AXI_BVALID, S_AXI_BRESP,
      output S_AXI_BREADY,
      output S_AXI_ARVALID, S_AXI_ARADDR, S_AXI_ARPROT,
      input  S_AXI_ARREADY,
      input  S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP,
      output S_AXI_RREADY
   );
endinterface

// File: rtl/axi_4_lite_slv_param.sv
// Parametrised AXI4-Lite slave register file with RO status registers,
// independent AW/W holds, B/R backpressure and per-register write pulses.
module axi_4_lite_slv_param #(
   parameter int C_AXI_DATA_WIDTH   = 32,
   parameter int C_AXI_ADDR_WIDTH   = 8,
   parameter int C_REGISTERS_NUMBER = 8,
   parameter logic [C_REGISTERS_NUMBER-1:0] C_RO_MASK = '0
) (
   input  logic S_AXI_ACLK,
   input  logic S_AXI_ARESETN,
   axi_4_lite_slv_param_if.slave s_axi,
   output logic [C_REGISTERS_NUMBER*C_AXI_DATA_WIDTH-1:0] usr_regs_out,
   input  logic [C_REGISTERS_NUMBER*C_AXI_DATA_WIDTH-1:0] usr_ro_in,
   output logic [C_REGISTERS_NUMBER-1:0] usr_wr_stb
);
   localparam int DW  = C_AXI_DATA_WIDTH;
   localparam int AW  = C_AXI_ADDR_WIDTH;
   localparam int N   = C_REGISTERS_NUMBER;
   localparam int SW  = DW / 8;
   localparam int LSB = $clog2(SW);
   localparam int IW  = AW - LSB;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] DECERR = 2'b11;

   logic          rst_done;
   logic          aw_held, w_held, ar_held;
   logic [IW-1:0] aw_idx, ar_idx;
   logic [DW-1:0] w_data;
   logic [SW-1:0] w_strb;
   logic [DW-1:0] regs [N];
   logic          bvalid, rvalid;
   logic [1:0]    bresp, rresp;
   logic [DW-1:0] rdata;
   logic [N-1:0]  wr_stb;

   logic          aw_hs, w_hs, ar_hs;
   logic          commit, rd_cap;
   logic [1:0]    wr_resp, rd_resp;
   logic [N-1:0]  wr_sel;
   logic [DW-1:0] rd_data;
   logic          unused_ok;

   assign s_axi.S_AXI_AWREADY = rst_done & ~aw_held;
   assign s_axi.S_AXI_WREADY  = rst_done & ~w_held;
   assign s_axi.S_AXI_ARREADY = rst_done & ~ar_held;
   assign s_axi.S_AXI_BVALID  = bvalid;
   assign s_axi.S_AXI_BRESP   = bresp;
   assign s_axi.S_AXI_RVALID  = rvalid;
   assign s_axi.S_AXI_RRESP   = rresp;
   assign s_axi.S_AXI_RDATA   = rdata;
   assign usr_wr_stb          = wr_stb;

   assign aw_hs  = s_axi.S_AXI_AWVALID & s_axi.S_AXI_AWREADY;
   assign w_hs   = s_axi.S_AXI_WVALID & s_axi.S_AXI_WREADY;
   assign ar_hs  = s_axi.S_AXI_ARVALID & s_axi.S_AXI_ARREADY;
   assign commit = aw_held & w_held & (~bvalid | s_axi.S_AXI_BREADY);
   assign rd_cap = ar_held & (~rvalid | s_axi.S_AXI_RREADY);

   assign unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                        s_axi.S_AXI_AWADDR[LSB-1:0],
                        s_axi.S_AXI_ARADDR[LSB-1:0]};

   always_comb begin
      wr_resp = DECERR;
      wr_sel  = '0;
      for (int i = 0; i < N; i++) begin
         if (aw_idx == IW'(i)) begin
            if (C_RO_MASK[i]) begin
               wr_resp = SLVERR;
            end else begin
               wr_resp   = OKAY;
               wr_sel[i] = |w_strb;
            end
         end
      end
   end

   // RO slots return the live status input, sampled at capture
   always_comb begin
      rd_resp = DECERR;
      rd_data = '0;
      for (int i = 0; i < N; i++) begin
         if (ar_idx == IW'(i)) begin
            rd_resp = OKAY;
            rd_data = C_RO_MASK[i] ? usr_ro_in[i*DW +: DW] : regs[i];
         end
      end
   end

   always_comb begin
      usr_regs_out = '0;
      for (int i = 0; i < N; i++) begin
         usr_regs_out[i*DW +: DW] = regs[i];
      end
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         for (int i = 0; i < N; i++) regs[i] <= '0;
      end else if (commit) begin
         for (int i = 0; i < N; i++) begin
            for (int b = 0; b < SW; b++) begin
               if (wr_sel[i] && w_strb[b])
                  regs[i][b*8 +: 8] <= w_data[b*8 +: 8];
            end
         end
      end
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         rst_done <= 1'b0;
         aw_held  <= 1'b0;
         w_held   <= 1'b0;
         ar_held  <= 1'b0;
         aw_idx   <= '0;
         ar_idx   <= '0;
         w_data   <= '0;
         w_strb   <= '0;
         bvalid   <= 1'b0;
         bresp    <= OKAY;
         wr_stb   <= '0;
         rvalid   <= 1'b0;
         rresp    <= OKAY;
         rdata    <= '0;
      end else begin
         rst_done <= 1'b1;
         wr_stb   <= '0;
         if (commit) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            bvalid  <= 1'b1;
            bresp   <= wr_resp;
            wr_stb  <= wr_sel;
         end else begin
            if (aw_hs) begin
               aw_held <= 1'b1;
               aw_idx  <= s_axi.S_AXI_AWADDR[AW-1:LSB];
            end
            if (w_hs) begin
               w_held <= 1'b1;
               w_data <= s_axi.S_AXI_WDATA;
               w_strb <= s_axi.S_AXI_WSTRB;
            end
            if (s_axi.S_AXI_BREADY) bvalid <= 1'b0;
         end
         if (rd_cap) begin
            ar_held <= 1'b0;
            rvalid  <= 1'b1;
            rdata   <= rd_data;
            rresp   <= rd_resp;
         end else begin
            if (ar_hs) begin
               ar_held <= 1'b1;
               ar_idx  <= s_axi.S_AXI_ARADDR[AW-1:LSB];
            end
            if (s_axi.S_AXI_RREADY) rvalid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_axi_4_lite_slv_param.sv
// Bench for axi_4_lite_slv_param: directed vector table, corner sequences
// and randomized traffic against a register-array reference model.
module tb_axi_4_lite_slv_param;
   localparam int NR = 8;
   localparam logic [NR-1:0] RO_MASK = 8'h04;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic [NR*32-1:0] regs_out;
   logic [NR*32-1:0] ro_in;
   logic [NR-1:0] wr_stb;

   int checks = 0;
   int errors = 0;

   logic [31:0] mdl [NR];
   logic [31:0] ro_val [NR];

   axi_4_lite_slv_param_if #(.DW(32), .AW(8)) bus ();

   axi_4_lite_slv_param #(
      .C_AXI_DATA_WIDTH(32),
      .C_AXI_ADDR_WIDTH(8),
      .C_REGISTERS_NUMBER(NR),
      .C_RO_MASK(RO_MASK)
   ) dut (
      .S_AXI_ACLK(clk),
      .S_AXI_ARESETN(rstn),
      .s_axi(bus),
      .usr_regs_out(regs_out),
      .usr_ro_in(ro_in),
      .usr_wr_stb(wr_stb)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          wr;
      logic [7:0]  a;
      logic [31:0] d;
      logic [3:0]  s;
      logic [1:0]  er;
      logic [31:0] ed;
      logic [7:0]  es;
   } vec_t;

   vec_t tbl [14];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %h required %h", nm, act, exp);
      end
   endtask

   task automatic tmo(input string nm);
      checks++;
      errors++;
      $display("FAIL %s timeout", nm);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mwrite(input logic [7:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [1:0] r,
                         output logic [7:0] stb);
      int idx;
      idx = int'(a) / 4;
      stb = '0;
      if (idx >= NR) r = 2'b11;
      else if (RO_MASK[idx]) r = 2'b10;
      else begin
         r = 2'b00;
         if (s != 0) stb = 8'(1 << idx);
         for (int b = 0; b < 4; b++)
            if (s[b]) mdl[idx][b*8 +: 8] = d[b*8 +: 8];
      end
   endtask

   task automatic mread(input logic [7:0] a, output logic [31:0] d,
                        output logic [1:0] r);
      int idx;
      idx = int'(a) / 4;
      if (idx >= NR) begin d = '0; r = 2'b11; end
      else if (RO_MASK[idx]) begin d = ro_val[idx]; r = 2'b00; end
      else begin d = mdl[idx]; r = 2'b00; end
   endtask

   task automatic do_write(input logic [7:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int bdly,
                           output logic [1:0] resp,
                           output logic [7:0] stb0,
                           output logic [7:0] stb1, output int lat);
      bit ad, wd, pa, pw;
      int n;
      ad = 0; wd = 0; n = 0;
      bus.S_AXI_AWADDR = a;
      bus.S_AXI_WDATA = d;
      bus.S_AXI_WSTRB = s;
      bus.S_AXI_AWVALID = 1'b1;
      bus.S_AXI_WVALID = 1'b1;
      bus.S_AXI_BREADY = 1'b0;
      while (!(ad && wd) && n < 50) begin
         pa = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
         pw = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
         tick();
         n++;
         if (pa) begin ad = 1; bus.S_AXI_AWVALID = 1'b0; end
         if (pw) begin wd = 1; bus.S_AXI_WVALID = 1'b0; end
      end
      if (!(ad && wd)) tmo("aw_w_handshake");
      lat = 0;
      while (!bus.S_AXI_BVALID && lat < 50) begin tick(); lat++; end
      if (!bus.S_AXI_BVALID) tmo("bvalid");
      resp = bus.S_AXI_BRESP;
      stb0 = wr_stb;
      bus.S_AXI_BREADY = (bdly == 0);
      tick();
      stb1 = wr_stb;
      for (int k = 1; k <= bdly; k++) begin
         chk("b_hold", {bus.S_AXI_BVALID, bus.S_AXI_BRESP}, {1'b1, resp});
         if (k == bdly) bus.S_AXI_BREADY = 1'b1;
         tick();
      end
      bus.S_AXI_BREADY = 1'b0;
      chk("b_drop", bus.S_AXI_BVALID, 0);
   endtask

   task automatic do_read(input logic [7:0] a, input int rdly,
                          output logic [31:0] d, output logic [1:0] resp,
                          output int lat);
      bit done, p;
      int n;
      done = 0; n = 0;
      bus.S_AXI_ARADDR = a;
      bus.S_AXI_ARVALID = 1'b1;
      bus.S_AXI_RREADY = 1'b0;
      while (!done && n < 50) begin
         p = bus.S_AXI_ARREADY;
         tick();
         n++;
         if (p) begin done = 1; bus.S_AXI_ARVALID = 1'b0; end
      end
      if (!done) tmo("ar_handshake");
      lat = 0;
      while (!bus.S_AXI_RVALID && lat < 50) begin tick(); lat++; end
      if (!bus.S_AXI_RVALID) tmo("rvalid");
      d = bus.S_AXI_RDATA;
      resp = bus.S_AXI_RRESP;
      bus.S_AXI_RREADY = (rdly == 0);
      tick();
      for (int k = 1; k <= rdly; k++) begin
         chk("r_hold", {bus.S_AXI_RVALID, bus.S_AXI_RRESP, bus.S_AXI_RDATA},
             {1'b1, resp, d});
         if (k == rdly) bus.S_AXI_RREADY = 1'b1;
         tick();
      end
      bus.S_AXI_RREADY = 1'b0;
      chk("r_drop", bus.S_AXI_RVALID, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      logic [1:0] r, er;
      logic [7:0] s0, s1, es;
      logic [31:0] d, ed;
      logic [7:0] ra;
      int lat;

      tbl[0]  = '{1, 8'h04, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0, 8'h02};
      tbl[1]  = '{0, 8'h04, 32'h0, 4'h0, 2'b00, 32'hDEADBEEF, 8'h00};
      tbl[2]  = '{1, 8'h08, 32'hCAFEF00D, 4'hF, 2'b10, 32'h0, 8'h00};
      tbl[3]  = '{0, 8'h08, 32'h0, 4'h0, 2'b00, 32'h12345678, 8'h00};
      tbl[4]  = '{1, 8'h40, 32'h11111111, 4'hF, 2'b11, 32'h0, 8'h00};
      tbl[5]  = '{0, 8'h40, 32'h0, 4'h0, 2'b11, 32'h0, 8'h00};
      tbl[6]  = '{1, 8'h00, 32'h11223344, 4'h0, 2'b00, 32'h0, 8'h00};
      tbl[7]  = '{0, 8'h00, 32'h0, 4'h0, 2'b00, 32'h0, 8'h00};
      tbl[8]  = '{1, 8'h1C, 32'hAABBCCDD, 4'h5, 2'b00, 32'h0, 8'h80};
      tbl[9]  = '{0, 8'h1E, 32'h0, 4'h0, 2'b00, 32'h00BB00DD, 8'h00};
      tbl[10] = '{1, 8'h7F, 32'h00000001, 4'hF, 2'b11, 32'h0, 8'h00};
      tbl[11] = '{0, 8'h3C, 32'h0, 4'h0, 2'b11, 32'h0, 8'h00};
      tbl[12] = '{1, 8'h1B, 32'h0000FF00, 4'h2, 2'b00, 32'h0, 8'h40};
      tbl[13] = '{0, 8'h18, 32'h0, 4'h0, 2'b00, 32'h0000FF00, 8'h00};

      for (int i = 0; i < NR; i++) begin
         mdl[i] = '0;
         ro_val[i] = (i == 2) ? 32'h12345678 : (32'hA5A50000 + 32'(i));
         ro_in[i*32 +: 32] = ro_val[i];
      end
      bus.S_AXI_AWVALID = 0; bus.S_AXI_AWADDR = 0; bus.S_AXI_AWPROT = 0;
      bus.S_AXI_WVALID = 0; bus.S_AXI_WDATA = 0; bus.S_AXI_WSTRB = 0;
      bus.S_AXI_BREADY = 0;
      bus.S_AXI_ARVALID = 0; bus.S_AXI_ARADDR = 0; bus.S_AXI_ARPROT = 0;
      bus.S_AXI_RREADY = 0;

      rstn = 1'b0;
      repeat (3) tick();
      chk("rst_ready", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY,
                        bus.S_AXI_ARREADY}, 3'b000);
      chk("rst_valid", {bus.S_AXI_BVALID, bus.S_AXI_RVALID, wr_stb}, 0);
      chk("rst_resp", {bus.S_AXI_BRESP, bus.S_AXI_RRESP, bus.S_AXI_RDATA}, 0);
      chk("rst_regs", {32'h0, regs_out[31:0] | regs_out[63:32]}, 0);
      rstn = 1'b1;
      tick();
      chk("ready_after_rst", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY,
                              bus.S_AXI_ARREADY}, 3'b111);

      for (int i = 0; i < 14; i++) begin
         if (tbl[i].wr) begin
            mwrite(tbl[i].a, tbl[i].d, tbl[i].s, er, es);
            do_write(tbl[i].a, tbl[i].d, tbl[i].s, i % 3, r, s0, s1, lat);
            chk($sformatf("tbl%0d_bresp", i), r, tbl[i].er);
            chk($sformatf("tbl%0d_stb", i), s0, tbl[i].es);
            chk($sformatf("tbl%0d_stb_next", i), s1, 0);
            chk($sformatf("tbl%0d_b_lat", i), lat, 1);
            if (i == 0) chk("tbl0_reg1", regs_out[63:32], 32'hDEADBEEF);
         end else begin
            do_read(tbl[i].a, i % 3, d, r, lat);
            chk($sformatf("tbl%0d_rresp", i), r, tbl[i].er);
            chk($sformatf("tbl%0d_rdata", i), d, tbl[i].ed);
            chk($sformatf("tbl%0d_r_lat", i), lat, 1);
         end
      end

      // W arrives three cycles before AW
      bus.S_AXI_WDATA = 32'h000000AA;
      bus.S_AXI_WSTRB = 4'h1;
      bus.S_AXI_WVALID = 1'b1;
      tick();
      bus.S_AXI_WVALID = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("wfirst_wready_low", bus.S_AXI_WREADY, 0);
         chk("wfirst_no_b", bus.S_AXI_BVALID, 0);
         if (k < 2) tick();
      end
      bus.S_AXI_AWADDR = 8'h04;
      bus.S_AXI_AWVALID = 1'b1;
      tick();
      bus.S_AXI_AWVALID = 1'b0;
      chk("wfirst_b_not_yet", bus.S_AXI_BVALID, 0);
      tick();
      mwrite(8'h04, 32'h000000AA, 4'h1, er, es);
      chk("wfirst_b", {bus.S_AXI_BVALID, bus.S_AXI_BRESP, wr_stb},
          {1'b1, er, es});
      chk("wfirst_reg1", regs_out[63:32], 32'hDEADBEAA);
      bus.S_AXI_BREADY = 1'b1;
      tick();
      bus.S_AXI_BREADY = 1'b0;
      chk("wfirst_ready_back", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 2'b11);

      // R backpressure with a second AR parked behind the first
      bus.S_AXI_ARADDR = 8'h04;
      bus.S_AXI_ARVALID = 1'b1;
      bus.S_AXI_RREADY = 1'b0;
      tick();
      bus.S_AXI_ARVALID = 1'b0;
      chk("bp_ar_held", {bus.S_AXI_ARREADY, bus.S_AXI_RVALID}, 2'b00);
      tick();
      chk("bp_first_r", {bus.S_AXI_RVALID, bus.S_AXI_RRESP, bus.S_AXI_RDATA},
          {1'b1, 2'b00, mdl[1]});
      chk("bp_arready_back", bus.S_AXI_ARREADY, 1);
      bus.S_AXI_ARADDR = 8'h1C;
      bus.S_AXI_ARVALID = 1'b1;
      tick();
      bus.S_AXI_ARVALID = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk("bp_r_stable", {bus.S_AXI_RVALID, bus.S_AXI_RRESP,
                             bus.S_AXI_RDATA}, {1'b1, 2'b00, mdl[1]});
         chk("bp_ar2_parked", bus.S_AXI_ARREADY, 0);
         tick();
      end
      bus.S_AXI_RREADY = 1'b1;
      tick();
      chk("bp_second_r", {bus.S_AXI_RVALID, bus.S_AXI_RDATA},
          {1'b1, mdl[7]});
      tick();
      bus.S_AXI_RREADY = 1'b0;
      chk("bp_r_done", bus.S_AXI_RVALID, 0);

      // reset with BVALID pending and AW held
      bus.S_AXI_AWADDR = 8'h00;
      bus.S_AXI_WDATA = 32'h00000055;
      bus.S_AXI_WSTRB = 4'hF;
      bus.S_AXI_AWVALID = 1'b1;
      bus.S_AXI_WVALID = 1'b1;
      tick();
      bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WVALID = 1'b0;
      tick();
      chk("mid_bvalid", bus.S_AXI_BVALID, 1);
      bus.S_AXI_AWADDR = 8'h0C;
      bus.S_AXI_AWVALID = 1'b1;
      tick();
      bus.S_AXI_AWVALID = 1'b0;
      chk("mid_aw_held", bus.S_AXI_AWREADY, 0);
      rstn = 1'b0;
      tick();
      chk("mid_rst_out", {bus.S_AXI_BVALID, bus.S_AXI_AWREADY,
                          bus.S_AXI_WREADY, wr_stb}, 0);
      chk("mid_rst_regs", {32'h0, regs_out[31:0] | regs_out[63:32] |
                           regs_out[255:224]}, 0);
      rstn = 1'b1;
      for (int i = 0; i < NR; i++) mdl[i] = '0;
      bus.S_AXI_WDATA = 32'h00000099;
      bus.S_AXI_WVALID = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("mid_no_commit", {bus.S_AXI_BVALID, wr_stb}, 0);
      end
      bus.S_AXI_WVALID = 1'b0;
      chk("mid_regs_zero", {32'h0, regs_out[31:0] | regs_out[127:96]}, 0);
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      tick();

      for (int i = 0; i < 60; i++) begin
         ra = 8'($urandom_range(0, 8'h4F));
         if ($urandom_range(0, 1) == 1) begin
            d = $urandom;
            s0 = 8'($urandom_range(0, 15));
            mwrite(ra, d, s0[3:0], er, es);
            do_write(ra, d, s0[3:0], $urandom_range(0, 3), r, s0, s1, lat);
            chk($sformatf("rnd%0d_bresp", i), r, er);
            chk($sformatf("rnd%0d_stb", i), s0, es);
            chk($sformatf("rnd%0d_stb_next", i), s1, 0);
         end else begin
            mread(ra, ed, er);
            do_read(ra, $urandom_range(0, 3), d, r, lat);
            chk($sformatf("rnd%0d_rresp", i), r, er);
            chk($sformatf("rnd%0d_rdata", i), d, ed);
         end
      end
      for (int i = 0; i < NR; i++)
         chk($sformatf("final_reg%0d", i), regs_out[i*32 +: 32], mdl[i]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/axi_4_lite_slv_param.md
Name: axi_4_lite_slv_param

Overview:
Parametrised AXI4-Lite slave register file, successor to the fixed-size slave. It adds:
- Configurable data width and register count.
- Independent AW/W acceptance.
- Full B/R backpressure.
- Read-only registers fed from user logic.
- DECERR/SLVERR responses.
- Per-register write-notify pulses.

It sits between the AXI interconnect and user control/status logic.

Parameters:
C_AXI_DATA_WIDTH, 32, data width; 32 or 64 only.
C_AXI_ADDR_WIDTH, 8, byte address width.
C_REGISTERS_NUMBER, 8, number of registers; 1..2^(C_AXI_ADDR_WIDTH-C_ADDR_LSB).
C_RO_MASK, 0, C_REGISTERS_NUMBER bits; bit i=1 makes register i read-only (status).

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESETN  in  1  synchronous active-low reset
S_AXI_AWVALID/S_AXI_AWREADY  in/out  1  write address handshake
S_AXI_AWADDR  in  C_AXI_ADDR_WIDTH  write byte address
S_AXI_AWPROT  in  3  ignored
S_AXI_WVALID/S_AXI_WREADY  in/out  1  write data handshake
S_AXI_WDATA  in  C_AXI_DATA_WIDTH  write data
S_AXI_WSTRB  in  C_AXI_DATA_WIDTH/8  byte strobes
S_AXI_BVALID/S_AXI_BREADY  out/in  1  write response handshake
S_AXI_BRESP  out  2  write response
S_AXI_ARVALID/S_AXI_ARREADY  in/out  1  read address handshake
S_AXI_ARADDR  in  C_AXI_ADDR_WIDTH  read byte address
S_AXI_ARPROT  in  3  ignored
S_AXI_RVALID/S_AXI_RREADY  out/in  1  read data handshake
S_AXI_RDATA  out  C_AXI_DATA_WIDTH  read data
S_AXI_RRESP  out  2  read response
usr_regs_out  out  C_REGISTERS_NUMBER*C_AXI_DATA_WIDTH  flat register contents; register i at slice i
usr_ro_in  in  C_REGISTERS_NUMBER*C_AXI_DATA_WIDTH  status values for RO registers; slice i used only when C_RO_MASK[i]=1
usr_wr_stb  out  C_REGISTERS_NUMBER  one-cycle pulse per successfully written RW register

Behaviour:
- Addressing:
  - C_ADDR_LSB = log2(C_AXI_DATA_WIDTH/8).
  - index = addr[C_AXI_ADDR_WIDTH-1:C_ADDR_LSB]; low address bits are ignored.
  - index >= C_REGISTERS_NUMBER is out of range.
- Reset (ARESETN low at edge):
  - All RW registers = 0; BVALID, RVALID, usr_wr_stb = 0; BRESP, RRESP = 2'b00; RDATA = 0.
  - AWREADY, WREADY, ARREADY = 0 during reset and 1 from the first edge after reset release.
  - Reset mid-transaction drops all held addresses, data and pending responses; no register write occurs.
- Write channel: AW and W are accepted independently, in any order or simultaneously.
  - Each channel has a one-entry hold register. AWREADY = !aw_held; WREADY = !w_held.
  - Commit occurs on the edge where aw_held && w_held && (!BVALID || BREADY).
  - So BVALID rises one cycle after the later of the two handshakes when the B slot is free.
  - Commit clears both holds, so READY reasserts on the next cycle.
  - BVALID/BRESP hold stable until BREADY; BVALID drops on the handshake edge unless a new commit occurs on that same edge.
- Write responses:
  - In range, RW: byte lanes with WSTRB[k]=1 update; usr_wr_stb[index] pulses for exactly one cycle, coincident with BVALID rising; BRESP = OKAY (2'b00).
  - WSTRB = 0: no change, no pulse, OKAY.
  - In range, RO: no change, no pulse, SLVERR (2'b10).
  - Out of range: no change, no pulse, DECERR (2'b11).
- Read channel: ARREADY = !ar_held.
  - Data capture occurs on the edge where ar_held && (!RVALID || RREADY).
  - At capture: RVALID=1, ar_held cleared.
  - RDATA = register value for RW, usr_ro_in slice sampled at the capture edge for RO, 0 for out of range.
  - RRESP = OKAY, OKAY, DECERR respectively.
  - RDATA/RRESP hold stable while RVALID && !RREADY.
- Simultaneous events:
  - A read capture and a write commit to the same register on the same edge: read returns the pre-write value.
  - Read and write paths never stall each other.
- Throughput: one write per 2 cycles and one read per 2 cycles under continuous VALID/READY.

Test Plan:
- Reset, then AW=0x04 and W=0xDEADBEEF with WSTRB=0xF in the same cycle, BREADY=1 -> BVALID one cycle later with BRESP=00; usr_wr_stb=0x02 for one cycle; usr_regs_out slice1=0xDEADBEEF.
- W first (0x000000AA, WSTRB=0x1), AW (0x04) three cycles later, prior reg1=0xDEADBEEF -> WREADY low while waiting; commit after AW; reg1=0xDEADBEAA.
- C_RO_MASK=0x04, usr_ro_in slice2=0x12345678: write 0x08 -> BRESP=10, no usr_wr_stb; read 0x08 -> RDATA=0x12345678, RRESP=00.
- Write and read of 0x40 with 8 registers -> BRESP=11; RDATA=0, RRESP=11; no register changes.
- Hold RREADY=0 for 5 cycles after a read of reg1 -> RVALID and RDATA stable; ARREADY reasserts after AR capture, second AR held until R handshake, then its data follows on the next edge.
- Assert ARESETN low with AW held and BVALID high -> all outputs at reset values next edge; registers 0; no commit after release.
